// File: rtl/echo_delay_meter.sv
`default_nettype none
// ============================================================================
// Module      : echo_delay_meter
// Description : Emits a square-wave ping on amp_out, then times the first
//               threshold crossing on each mic channel. The ping is repeated
//               2^AVG_LOG2 times and the per-channel delays are averaged.
//               Delays are expressed in step_in (48 kHz sample) periods.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in        audio clock
//   rst_in        asynchronous active-low reset
//   step_in       single-cycle sample strobe
//   trigger_in    single-cycle start request (honoured in IDLE only)
//   threshold_in  unsigned detection threshold
//   mic_in        packed signed mic samples, ch0 in LSBs
//   amp_out       signed ping waveform
//   delay_out     packed averaged delays, ch0 in LSBs
//   ch_valid_out  per channel: 1 = detected on every ping
//   done_out      one-cycle pulse when results update
//   busy_out      high in any state except IDLE
//   state_out     IDLE=0, PING=1, LISTEN=2, QUIET=3, DONE=4
// ============================================================================
module echo_delay_meter #(
    parameter int NUM_CH    = 3,
    parameter int SAMPLE_W  = 16,
    parameter int DELAY_W   = 8,
    parameter int PING_LEN  = 16,
    parameter int PING_AMP  = 12000,
    parameter int QUIET_LEN = 64,
    parameter int AVG_LOG2  = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        step_in,
    input  logic                        trigger_in,
    input  logic [SAMPLE_W-1:0]         threshold_in,
    input  logic [NUM_CH*SAMPLE_W-1:0]  mic_in,
    output logic [SAMPLE_W-1:0]         amp_out,
    output logic [NUM_CH*DELAY_W-1:0]   delay_out,
    output logic [NUM_CH-1:0]           ch_valid_out,
    output logic                        done_out,
    output logic                        busy_out,
    output logic [2:0]                  state_out
);

    localparam int ACC_W = DELAY_W + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int Q_W   = $clog2(QUIET_LEN + 1);

    localparam logic [DELAY_W-1:0]  C_T_LAST     = {DELAY_W{1'b1}};
    localparam logic [DELAY_W-1:0]  C_PING_LAST  = DELAY_W'(PING_LEN - 1);
    localparam logic [Q_W-1:0]      C_QUIET_LAST = Q_W'(QUIET_LEN - 1);
    localparam logic [IDX_W-1:0]    C_IDX_LAST   = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [SAMPLE_W-1:0] C_AMP_POS    = SAMPLE_W'(PING_AMP);
    localparam logic [SAMPLE_W-1:0] C_AMP_NEG    = SAMPLE_W'(-PING_AMP);
    localparam logic [SAMPLE_W-1:0] C_SMAX       = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] C_SMIN       = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PING   = 3'd1,
        S_LISTEN = 3'd2,
        S_QUIET  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic [DELAY_W-1:0]      r_t;       // value of t for the next strobe
    logic [Q_W-1:0]          r_q;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_CH-1:0]       r_hit;     // hit already recorded this ping
    logic [NUM_CH-1:0]       r_miss;    // sticky: missed on some ping
    logic [ACC_W-1:0]        r_acc [NUM_CH];

    logic [NUM_CH-1:0]         w_over;
    logic [NUM_CH-1:0]         w_new_hit;
    logic [NUM_CH-1:0]         w_hit_all;
    logic [NUM_CH*DELAY_W-1:0] w_res;

    // Per-channel magnitude compare and final result formatting.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SAMPLE_W-1:0] w_s;
        logic [SAMPLE_W-1:0] w_mag;

        assign w_s = mic_in[g*SAMPLE_W +: SAMPLE_W];

        // The most negative sample has no positive twin; clamp it to max.
        always_comb begin
            if (w_s == C_SMIN) begin
                w_mag = C_SMAX;
            end else if (w_s[SAMPLE_W-1]) begin
                w_mag = -w_s;
            end else begin
                w_mag = w_s;
            end
        end

        assign w_over[g] = (w_mag > threshold_in);

        // Average is the upper DELAY_W bits of the accumulator.
        assign w_res[g*DELAY_W +: DELAY_W] =
            r_miss[g] ? {DELAY_W{1'b1}} : r_acc[g][ACC_W-1 -: DELAY_W];
    end

    assign w_new_hit = w_over & ~r_hit;
    assign w_hit_all = r_hit | w_over;

    assign state_out = r_state;
    assign busy_out  = r_busy;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_t          <= '0;
            r_q          <= '0;
            r_idx        <= '0;
            r_hit        <= '0;
            r_miss       <= '0;
            amp_out      <= '0;
            delay_out    <= '0;
            ch_valid_out <= '0;
            done_out     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    amp_out <= '0;
                    // A strobe in the trigger cycle is not used by PING.
                    if (trigger_in) begin
                        r_state <= S_PING;
                        r_busy  <= 1'b1;
                        r_t     <= '0;
                        r_idx   <= '0;
                        r_hit   <= '0;
                        r_miss  <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end

                S_PING: begin
                    if (step_in) begin
                        amp_out <= r_t[0] ? C_AMP_NEG : C_AMP_POS;
                        r_t     <= r_t + 1'b1;
                        // Last half-cycle stays on amp_out until the first
                        // LISTEN strobe zeroes it.
                        if (r_t == C_PING_LAST) begin
                            r_state <= S_LISTEN;
                        end
                    end
                end

                S_LISTEN: begin
                    if (step_in) begin
                        amp_out <= '0;
                        r_hit   <= w_hit_all;
                        r_t     <= r_t + 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (w_new_hit[i]) begin
                                r_acc[i] <= r_acc[i] + ACC_W'(r_t);
                            end
                        end
                        if ((&w_hit_all) || (r_t == C_T_LAST)) begin
                            r_state <= S_QUIET;
                            r_q     <= '0;
                            r_miss  <= r_miss | ~w_hit_all;
                        end
                    end
                end

                S_QUIET: begin
                    if (step_in) begin
                        if (r_q == C_QUIET_LAST) begin
                            if (r_idx != C_IDX_LAST) begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= S_PING;
                                r_t     <= '0;
                                r_hit   <= '0;
                            end else begin
                                // Results land together with the DONE state.
                                r_state      <= S_DONE;
                                done_out     <= 1'b1;
                                delay_out    <= w_res;
                                ch_valid_out <= ~r_miss;
                            end
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
